stack_alu_seq: RTL
==================

Name: stack_alu_seq

Overview:
Multicycle sequencer that owns the operand stack of the stack CPU and drives the shared 8-bit ALU.
- Accepts one stack command at a time over a valid/ready handshake.
- Reads the top-of-stack (TOS) and next-on-stack (NOS) entries into operand registers, then drives the ALU control and operands.
- Writes the result back to the stack and reports completion, result, zero flag and error status to the CPU control FSM.

Parameters:
DATA_W, 8, stack entry and ALU operand width; must match the ALU.
DEPTH, 16, number of stack entries.
CNT_W, 5, width of the depth counter; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer idle; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
cmd_op  in  3  000 PUSH, 001 POP, 100 ADD, 101 SUB, 110 AND, 111 NOT; 010 and 011 are illegal.
cmd_data  in  DATA_W  PUSH operand.
alu_a  out  DATA_W  ALU operand A.
alu_b  out  DATA_W  ALU operand B.
alu_ctrl  out  2  ALU function select: 00 add, 01 sub, 10 and, 11 not-A.
alu_result  in  DATA_W  combinational ALU result.
alu_zero  in  1  ALU zero flag.
done  out  1  one-cycle completion pulse.
err  out  1  valid with done; command failed.
err_code  out  2  00 none, 01 underflow, 10 overflow, 11 illegal op.
rsp_data  out  DATA_W  PUSH: pushed value; POP: popped value; ALU ops: result. Held until the next done.
zero_flag  out  1  registered alu_zero from the last EXEC; held otherwise.
depth  out  CNT_W  current number of stack entries.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE and clears depth, done, err, err_code, rsp_data, zero_flag, the operand registers and the latched op.
  - This applies mid-operation too: the in-flight command is dropped with no done pulse.
  - Stack RAM is not reset; no entry is read before it is written.
- cmd_ready = (state == IDLE) and done == 0. The cycle carrying the done pulse never accepts a command, so back-to-back accepts are at least one idle cycle apart.
- States: IDLE, RD_TOS, RD_NOS, EXEC, WB, ERR.
- Checks at acceptance edge E0 (cmd_op latched):
  - Illegal op -> ERR, err_code 11.
  - POP or NOT with depth < 1 -> ERR, err_code 01.
  - ADD, SUB or AND with depth < 2 -> ERR, err_code 01.
  - PUSH with depth == DEPTH -> ERR, err_code 10.
- ERR: next edge returns to IDLE with done=1, err=1. Stack, depth, rsp_data and zero_flag are unchanged.
- Legal command paths, one state per edge:
  - PUSH: E0 -> WB. E1 writes stack[depth]=cmd_data (latched at E0), depth+1, rsp_data=data.
  - POP: E0 -> RD_TOS -> WB. E1 captures tos=stack[depth-1]. E2 sets depth-1, rsp_data=tos.
  - NOT: E0 -> RD_TOS -> EXEC -> WB. E1 tos. E2 res=alu_result, zero_flag=alu_zero. E3 writes stack[depth-1]=res; depth unchanged.
  - ADD/SUB/AND: E0 -> RD_TOS -> RD_NOS -> EXEC -> WB. E1 tos. E2 nos=stack[depth-2]. E3 res, zero_flag. E4 writes stack[depth-2]=res, depth-1.
  - WB edge: sets done=1 (cleared the next cycle), err=0, err_code=00, rsp_data per op; next state IDLE.
- Latency from E0 to the done-high cycle: PUSH 1, POP 2, NOT 3, binary ops 4 cycles; ERR 1 cycle.
- ALU drive:
  - alu_a = nos for binary ops, tos for NOT.
  - alu_b = tos.
  - Operand order: SUB computes NOS - TOS.
  - alu_ctrl = cmd_op[1:0] for ALU ops, 00 otherwise.
  - Outputs are only meaningful in EXEC; they are registered-operand driven and stable throughout EXEC.
- Arithmetic wraps modulo 2^DATA_W; no carry or overflow flag.
- zero_flag updates only on the EXEC edge. PUSH, POP and errors leave it unchanged.
- cmd_valid, cmd_op and cmd_data are ignored outside the acceptance edge. Changes while busy have no effect.

Test Plan:
- Reset then PUSH 0x05, PUSH 0x03, SUB -> done after 1/1/4 cycles; rsp_data=0x02, depth=1, zero_flag=0, alu_ctrl=01 in EXEC.
- PUSH 0xF0, PUSH 0x20, ADD -> rsp_data=0x10 (wrap), depth=1; then POP -> rsp_data=0x10, depth=0.
- PUSH 0x0F, NOT -> rsp_data=0xF0, depth=1; PUSH 0x0F, AND -> rsp_data=0x00, zero_flag=1.
- Empty stack: POP -> done+err, err_code=01, depth=0; PUSH 0x01, ADD -> err_code=01, depth=1; cmd_op=010 -> err_code=11.
- DEPTH pushes of 0x00..0x0F, then PUSH 0xAA -> err_code=10, depth=16; 16 POPs return 0x0F..0x00 in order.
- Assert rst_n low during EXEC of an ADD -> no done, depth=0, cmd_ready=1 after release; next PUSH 0x07 completes normally.

Source files
------------

// File: rtl/stack_alu_seq.sv
// Operand-stack sequencer for the stack CPU: accepts one stack command at a time,
// stages TOS/NOS through operand registers, drives the shared ALU and writes back.
module stack_alu_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  depth
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_CNT   = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_TOS = 3'd1,
    S_RD_NOS = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        op_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] tos_reg;
  logic [DATA_W-1:0] nos_reg;
  logic [DATA_W-1:0] res_reg;
  logic [DATA_W-1:0] rsp_reg;
  logic [CNT_W-1:0]  depth_reg;
  logic              done_reg;
  logic              err_reg;
  logic [1:0]        err_code_reg;
  logic [1:0]        pend_code_reg;
  logic              zero_reg;

  logic              accept;
  logic [1:0]        chk_code;
  logic              op_is_binary;
  logic [CNT_W-1:0]  depth_m1;
  logic [CNT_W-1:0]  depth_m2;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  assign accept       = cmd_valid && cmd_ready;
  assign op_is_binary = op_reg[2] && (op_reg[1:0] != 2'b11);
  assign depth_m1     = depth_reg - ONE_CNT;
  assign depth_m2     = depth_reg - TWO_CNT;

  // Legality of the offered command, judged against the depth at acceptance.
  always_comb begin
    chk_code = ERR_NONE;
    case (cmd_op)
      OP_PUSH: if (depth_reg == DEPTH_CNT) chk_code = ERR_OVER;
      OP_POP, OP_NOT: if (depth_reg < ONE_CNT) chk_code = ERR_UNDER;
      OP_ADD, OP_SUB, OP_AND: if (depth_reg < TWO_CNT) chk_code = ERR_UNDER;
      default: chk_code = ERR_ILLEGAL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (chk_code != ERR_NONE)  state_next = S_ERR;
          else if (cmd_op == OP_PUSH) state_next = S_WB;
          else                        state_next = S_RD_TOS;
        end
      end
      S_RD_TOS: begin
        if (op_reg == OP_POP)      state_next = S_WB;
        else if (op_reg == OP_NOT) state_next = S_EXEC;
        else                       state_next = S_RD_NOS;
      end
      S_RD_NOS: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic: ALU drive comes straight from the operand registers, so it is
  // stable for the whole EXEC cycle.
  always_comb begin
    cmd_ready = (state_reg == S_IDLE) && !done_reg;
    alu_a     = op_is_binary ? nos_reg : tos_reg;
    alu_b     = tos_reg;
    alu_ctrl  = op_reg[2] ? op_reg[1:0] : 2'b00;
  end

  // Stack RAM ports
  always_comb begin
    rd_addr = (state_reg == S_RD_NOS) ? depth_m2[ADDR_W-1:0] : depth_m1[ADDR_W-1:0];
    wr_en   = (state_reg == S_WB) && (op_reg != OP_POP);
    wr_data = (op_reg == OP_PUSH) ? data_reg : res_reg;
    if (op_reg == OP_PUSH)   wr_addr = depth_reg[ADDR_W-1:0];
    else if (op_is_binary)   wr_addr = depth_m2[ADDR_W-1:0];
    else                     wr_addr = depth_m1[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg        <= '0;
      data_reg      <= '0;
      tos_reg       <= '0;
      nos_reg       <= '0;
      res_reg       <= '0;
      rsp_reg       <= '0;
      depth_reg     <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
      pend_code_reg <= ERR_NONE;
      zero_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_WB) || (state_reg == S_ERR);
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg        <= cmd_op;
            data_reg      <= cmd_data;
            pend_code_reg <= chk_code;
          end
        end
        S_RD_TOS: tos_reg <= mem[rd_addr];
        S_RD_NOS: nos_reg <= mem[rd_addr];
        S_EXEC: begin
          res_reg  <= alu_result;
          zero_reg <= alu_zero;
        end
        S_WB: begin
          err_reg      <= 1'b0;
          err_code_reg <= ERR_NONE;
          if (op_reg == OP_PUSH) begin
            rsp_reg   <= data_reg;
            depth_reg <= depth_reg + ONE_CNT;
          end else if (op_reg == OP_POP) begin
            rsp_reg   <= tos_reg;
            depth_reg <= depth_m1;
          end else begin
            rsp_reg <= res_reg;
            if (op_is_binary) depth_reg <= depth_m1;
          end
        end
        S_ERR: begin
          err_reg      <= 1'b1;
          err_code_reg <= pend_code_reg;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign rsp_data  = rsp_reg;
  assign zero_flag = zero_reg;
  assign depth     = depth_reg;

endmodule
